// File: rtl/parking_day_sequencer_if.sv
// Signal bundle between the parking day sequencer and its environment.
// The controller side (master) drives the day/car events; the sequencer
// (slave) returns grants, occupancy, rush strobes and day status.
interface parking_day_sequencer_if;
  logic       start;
  logic       hour_tick;
  logic       car_enter;
  logic       car_exit;
  logic       enter_grant;
  logic       exit_grant;
  logic [3:0] occupancy;
  logic       slot_full;
  logic       slot_empty;
  logic [3:0] work_hour;
  logic       rush_start_valid;
  logic       rush_end_valid;
  logic       day_done;
  logic [2:0] day_index;
  logic       busy;
  logic       finished;

  modport master (
    output start, hour_tick, car_enter, car_exit,
    input  enter_grant, exit_grant, occupancy, slot_full, slot_empty,
           work_hour, rush_start_valid, rush_end_valid, day_done,
           day_index, busy, finished
  );

  modport slave (
    input  start, hour_tick, car_enter, car_exit,
    output enter_grant, exit_grant, occupancy, slot_full, slot_empty,
           work_hour, rush_start_valid, rush_end_valid, day_done,
           day_index, busy, finished
  );
endinterface

// File: rtl/parking_day_sequencer.sv
// Parking work-day sequencer: lot occupancy, hour counting, rush-hour
// strobes and day bookkeeping.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | between days, waiting for start
// OPEN     | day running; cars accepted, hour ticks counted
// CLOSE    | single-cycle day close, day_done strobe
// FINISHED | all days done; absorbing until reset
//
// rush     | meaning
// ---------+-----------------------------------------------------------
// WAIT_FULL  | armed for the lot becoming full
// WAIT_EMPTY | rush started, waiting for the lot to drain
module parking_day_sequencer #(
  parameter int CAPACITY   = 3,
  parameter int WORK_HOURS = 8,
  parameter int DAYS       = 4
) (
  input logic                   clk,
  input logic                   reset,
  parking_day_sequencer_if.slave bus
);

  localparam logic [3:0] CAP       = 4'(CAPACITY);
  localparam logic [3:0] LAST_HOUR = 4'(WORK_HOURS - 1);
  localparam logic [2:0] LAST_DAY  = 3'(DAYS - 1);

  typedef enum logic [1:0] {IDLE, OPEN, CLOSE, FINISHED} state_t;
  typedef enum logic {WAIT_FULL, WAIT_EMPTY} rush_t;

  state_t     state;
  rush_t      rush_phase;
  logic [3:0] occupancy;
  logic [3:0] work_hour;
  logic [2:0] day_index;
  logic       busy;
  logic       finished;
  logic       day_done;
  logic       rush_start_valid;
  logic       rush_end_valid;
  logic       enter_grant;
  logic       exit_grant;

  // An exit in the same cycle frees a slot, so a full lot can still admit.
  assign exit_grant  = (state == OPEN) && bus.car_exit && (occupancy != 4'd0);
  assign enter_grant = (state == OPEN) && bus.car_enter &&
                       ((occupancy != CAP) || exit_grant);

  assign bus.enter_grant      = enter_grant;
  assign bus.exit_grant       = exit_grant;
  assign bus.occupancy        = occupancy;
  assign bus.slot_full        = (occupancy == CAP);
  assign bus.slot_empty       = (occupancy == 4'd0);
  assign bus.work_hour        = work_hour;
  assign bus.rush_start_valid = rush_start_valid;
  assign bus.rush_end_valid   = rush_end_valid;
  assign bus.day_done         = day_done;
  assign bus.day_index        = day_index;
  assign bus.busy             = busy;
  assign bus.finished         = finished;

  // Occupancy counter; persists across days, only moves on granted events.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      occupancy <= 4'd0;
    end else if (enter_grant && !exit_grant) begin
      occupancy <= occupancy + 4'd1;
    end else if (exit_grant && !enter_grant) begin
      occupancy <= occupancy - 4'd1;
    end
  end

  // Day FSM with the rush-phase tracker and all registered status outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state            <= IDLE;
      rush_phase       <= WAIT_FULL;
      work_hour        <= 4'd0;
      day_index        <= 3'd0;
      busy             <= 1'b0;
      finished         <= 1'b0;
      day_done         <= 1'b0;
      rush_start_valid <= 1'b0;
      rush_end_valid   <= 1'b0;
    end else begin
      day_done         <= 1'b0;
      rush_start_valid <= 1'b0;
      rush_end_valid   <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            state     <= OPEN;
            busy      <= 1'b1;
            work_hour <= 4'd0;
            // Occupancy cannot change in IDLE, so a full lot here is what the
            // first OPEN cycle shows; strobe it right there.
            if (occupancy == CAP) begin
              rush_start_valid <= 1'b1;
              rush_phase       <= WAIT_EMPTY;
            end else begin
              rush_phase <= WAIT_FULL;
            end
          end
        end
        OPEN: begin
          if (bus.hour_tick && (work_hour == LAST_HOUR)) begin
            // Leaving OPEN: suppress rush strobes so none lands in CLOSE.
            state    <= CLOSE;
            day_done <= 1'b1;
          end else begin
            if (bus.hour_tick) begin
              work_hour <= work_hour + 4'd1;
            end
            if ((rush_phase == WAIT_FULL) && (occupancy == CAP)) begin
              rush_start_valid <= 1'b1;
              rush_phase       <= WAIT_EMPTY;
            end else if ((rush_phase == WAIT_EMPTY) && (occupancy == 4'd0)) begin
              rush_end_valid <= 1'b1;
              rush_phase     <= WAIT_FULL;
            end
          end
        end
        CLOSE: begin
          busy <= 1'b0;
          if (day_index == LAST_DAY) begin
            state    <= FINISHED;
            finished <= 1'b1;
          end else begin
            state     <= IDLE;
            day_index <= day_index + 3'd1;
          end
        end
        FINISHED: begin
          state <= FINISHED;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_parking_day_sequencer.sv
// Directed bench for the parking day sequencer (CAPACITY=3, WORK_HOURS=4,
// DAYS=2). Inputs change 1 ns after the rising edge; outputs are sampled there.
module tb_parking_day_sequencer;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_pass;

  parking_day_sequencer_if bus ();

  parking_day_sequencer #(
    .CAPACITY  (3),
    .WORK_HOURS(4),
    .DAYS      (2)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  // 10 ns clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.start     = 1'b0;
    bus.hour_tick = 1'b0;
    bus.car_enter = 1'b0;
    bus.car_exit  = 1'b0;
  endtask

  task automatic apply_reset();
    clear_inputs();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    step();
  endtask

  task automatic open_day();
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
  endtask

  task automatic test_reset();
    apply_reset();
    open_day();
    bus.car_enter = 1'b1;
    step();
    step();
    bus.car_enter = 1'b0;
    n_checks++;
    if (bus.occupancy !== 4'd2) $display("FAIL reset_pre_occ: got %0d want 2", bus.occupancy);
    else n_pass++;
    n_checks++;
    if (bus.busy !== 1'b1) $display("FAIL reset_pre_busy: got %b want 1", bus.busy);
    else n_pass++;
    // async reset in the middle of a clock phase
    #2;
    reset = 1'b1;
    #1;
    n_checks++;
    if (bus.occupancy !== 4'd0) $display("FAIL reset_occ: got %0d want 0", bus.occupancy);
    else n_pass++;
    n_checks++;
    if ({bus.work_hour, bus.day_index} !== 7'd0)
      $display("FAIL reset_hour_day: got %0d/%0d want 0/0", bus.work_hour, bus.day_index);
    else n_pass++;
    n_checks++;
    if ({bus.busy, bus.finished, bus.day_done, bus.rush_start_valid, bus.rush_end_valid} !== 5'b0)
      $display("FAIL reset_flags: got %b want 00000",
               {bus.busy, bus.finished, bus.day_done, bus.rush_start_valid, bus.rush_end_valid});
    else n_pass++;
    n_checks++;
    if ({bus.slot_empty, bus.slot_full} !== 2'b10)
      $display("FAIL reset_slot_flags: got empty=%b full=%b want 1/0", bus.slot_empty, bus.slot_full);
    else n_pass++;
    @(negedge clk);
    reset = 1'b0;
    step();
    // IDLE: cars are refused
    bus.car_enter = 1'b1;
    #1;
    n_checks++;
    if (bus.enter_grant !== 1'b0) $display("FAIL reset_idle_grant: got %b want 0", bus.enter_grant);
    else n_pass++;
    step();
    bus.car_enter = 1'b0;
    n_checks++;
    if (bus.occupancy !== 4'd0) $display("FAIL reset_idle_occ: got %0d want 0", bus.occupancy);
    else n_pass++;
  endtask

  task automatic test_fill_drain();
    apply_reset();
    open_day();
    n_checks++;
    if ({bus.busy, bus.rush_start_valid} !== 2'b10)
      $display("FAIL fill_open: got busy=%b rsv=%b want 1/0", bus.busy, bus.rush_start_valid);
    else n_pass++;
    bus.car_enter = 1'b1;
    #1;
    n_checks++;
    if (bus.enter_grant !== 1'b1) $display("FAIL fill_grant: got %b want 1", bus.enter_grant);
    else n_pass++;
    for (int i = 1; i <= 3; i++) begin
      step();
      n_checks++;
      if (bus.occupancy !== 4'(i)) $display("FAIL fill_occ: got %0d want %0d", bus.occupancy, i);
      else n_pass++;
    end
    // occupancy just reached 3: strobe comes next cycle; 4th car refused
    n_checks++;
    if ({bus.slot_full, bus.rush_start_valid, bus.enter_grant} !== 3'b100)
      $display("FAIL sat_full: got full=%b rsv=%b grant=%b want 1/0/0",
               bus.slot_full, bus.rush_start_valid, bus.enter_grant);
    else n_pass++;
    step();
    bus.car_enter = 1'b0;
    n_checks++;
    if ({bus.occupancy, bus.rush_start_valid} !== {4'd3, 1'b1})
      $display("FAIL rush_start: got occ=%0d rsv=%b want 3/1", bus.occupancy, bus.rush_start_valid);
    else n_pass++;
    step();
    n_checks++;
    if (bus.rush_start_valid !== 1'b0) $display("FAIL rush_start_pulse: got %b want 0", bus.rush_start_valid);
    else n_pass++;
    // simultaneous enter+exit at full
    bus.car_enter = 1'b1;
    bus.car_exit  = 1'b1;
    #1;
    n_checks++;
    if ({bus.enter_grant, bus.exit_grant} !== 2'b11)
      $display("FAIL simul_full_grants: got %b%b want 11", bus.enter_grant, bus.exit_grant);
    else n_pass++;
    step();
    bus.car_enter = 1'b0;
    n_checks++;
    if ({bus.occupancy, bus.rush_start_valid} !== {4'd3, 1'b0})
      $display("FAIL simul_full_occ: got occ=%0d rsv=%b want 3/0", bus.occupancy, bus.rush_start_valid);
    else n_pass++;
    // drain
    for (int i = 2; i >= 0; i--) begin
      step();
      n_checks++;
      if ({bus.occupancy, bus.rush_end_valid} !== {4'(i), 1'b0})
        $display("FAIL drain_occ: got occ=%0d rev=%b want %0d/0", bus.occupancy, bus.rush_end_valid, i);
      else n_pass++;
    end
    n_checks++;
    if ({bus.exit_grant, bus.slot_empty} !== 2'b01)
      $display("FAIL sat_empty_grant: got grant=%b empty=%b want 0/1", bus.exit_grant, bus.slot_empty);
    else n_pass++;
    step();
    bus.car_exit = 1'b0;
    n_checks++;
    if ({bus.occupancy, bus.rush_end_valid} !== {4'd0, 1'b1})
      $display("FAIL rush_end: got occ=%0d rev=%b want 0/1", bus.occupancy, bus.rush_end_valid);
    else n_pass++;
    step();
    n_checks++;
    if (bus.rush_end_valid !== 1'b0) $display("FAIL rush_end_pulse: got %b want 0", bus.rush_end_valid);
    else n_pass++;
    // simultaneous enter+exit at empty
    bus.car_enter = 1'b1;
    bus.car_exit  = 1'b1;
    #1;
    n_checks++;
    if ({bus.enter_grant, bus.exit_grant} !== 2'b10)
      $display("FAIL simul_empty_grants: got %b%b want 10", bus.enter_grant, bus.exit_grant);
    else n_pass++;
    step();
    clear_inputs();
    n_checks++;
    if ({bus.occupancy, bus.work_hour} !== {4'd1, 4'd0})
      $display("FAIL simul_empty_occ: got occ=%0d hour=%0d want 1/0", bus.occupancy, bus.work_hour);
    else n_pass++;
  endtask

  task automatic test_day_sequencing();
    apply_reset();
    open_day();
    bus.car_enter = 1'b1;
    step();
    step();
    bus.car_enter = 1'b0;
    n_checks++;
    if ({bus.work_hour, bus.occupancy, bus.busy} !== {4'd0, 4'd2, 1'b1})
      $display("FAIL day1_open: got hour=%0d occ=%0d busy=%b want 0/2/1", bus.work_hour, bus.occupancy, bus.busy);
    else n_pass++;
    for (int h = 1; h <= 3; h++) begin
      bus.hour_tick = 1'b1;
      step();
      bus.hour_tick = 1'b0;
      n_checks++;
      if ({bus.work_hour, bus.day_done} !== {4'(h), 1'b0})
        $display("FAIL day1_hour: got hour=%0d done=%b want %0d/0", bus.work_hour, bus.day_done, h);
      else n_pass++;
    end
    // final tick with a car arriving in the same cycle
    bus.hour_tick = 1'b1;
    bus.car_enter = 1'b1;
    step();
    clear_inputs();
    n_checks++;
    if ({bus.day_done, bus.work_hour, bus.occupancy, bus.day_index} !== {1'b1, 4'd3, 4'd3, 3'd0})
      $display("FAIL day1_close: got done=%b hour=%0d occ=%0d day=%0d want 1/3/3/0",
               bus.day_done, bus.work_hour, bus.occupancy, bus.day_index);
    else n_pass++;
    n_checks++;
    if ({bus.busy, bus.rush_start_valid} !== 2'b10)
      $display("FAIL day1_close_flags: got busy=%b rsv=%b want 1/0", bus.busy, bus.rush_start_valid);
    else n_pass++;
    step();
    n_checks++;
    if ({bus.day_done, bus.day_index, bus.busy, bus.finished, bus.rush_start_valid} !== {1'b0, 3'd1, 3'b000})
      $display("FAIL day1_idle: got done=%b day=%0d busy=%b fin=%b rsv=%b want 0/1/0/0/0",
               bus.day_done, bus.day_index, bus.busy, bus.finished, bus.rush_start_valid);
    else n_pass++;
    // hour ticks and cars ignored while IDLE
    bus.hour_tick = 1'b1;
    bus.car_exit  = 1'b1;
    #1;
    n_checks++;
    if (bus.exit_grant !== 1'b0) $display("FAIL idle_exit_grant: got %b want 0", bus.exit_grant);
    else n_pass++;
    step();
    clear_inputs();
    n_checks++;
    if ({bus.work_hour, bus.occupancy} !== {4'd3, 4'd3})
      $display("FAIL idle_ignore: got hour=%0d occ=%0d want 3/3", bus.work_hour, bus.occupancy);
    else n_pass++;
  endtask

  task automatic test_second_day();
    open_day();
    n_checks++;
    if ({bus.rush_start_valid, bus.work_hour, bus.occupancy, bus.day_index} !== {1'b1, 4'd0, 4'd3, 3'd1})
      $display("FAIL day2_open: got rsv=%b hour=%0d occ=%0d day=%0d want 1/0/3/1",
               bus.rush_start_valid, bus.work_hour, bus.occupancy, bus.day_index);
    else n_pass++;
    step();
    n_checks++;
    if (bus.rush_start_valid !== 1'b0) $display("FAIL day2_rsv_pulse: got %b want 0", bus.rush_start_valid);
    else n_pass++;
    for (int h = 1; h <= 4; h++) begin
      bus.hour_tick = 1'b1;
      step();
      bus.hour_tick = 1'b0;
    end
    n_checks++;
    if ({bus.day_done, bus.work_hour, bus.finished} !== {1'b1, 4'd3, 1'b0})
      $display("FAIL day2_close: got done=%b hour=%0d fin=%b want 1/3/0", bus.day_done, bus.work_hour, bus.finished);
    else n_pass++;
    step();
    n_checks++;
    if ({bus.finished, bus.busy, bus.day_done, bus.day_index} !== {3'b100, 3'd1})
      $display("FAIL finished: got fin=%b busy=%b done=%b day=%0d want 1/0/0/1",
               bus.finished, bus.busy, bus.day_done, bus.day_index);
    else n_pass++;
    // FINISHED is absorbing
    bus.start = 1'b1;
    step();
    step();
    bus.start    = 1'b0;
    bus.car_exit = 1'b1;
    #1;
    n_checks++;
    if ({bus.finished, bus.busy, bus.exit_grant, bus.rush_start_valid} !== 4'b1000)
      $display("FAIL finished_hold: got fin=%b busy=%b xg=%b rsv=%b want 1/0/0/0",
               bus.finished, bus.busy, bus.exit_grant, bus.rush_start_valid);
    else n_pass++;
    step();
    clear_inputs();
    n_checks++;
    if (bus.occupancy !== 4'd3) $display("FAIL finished_occ: got %0d want 3", bus.occupancy);
    else n_pass++;
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    reset    = 1'b1;
    clear_inputs();
    test_reset();
    test_fill_drain();
    test_day_sequencing();
    test_second_day();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
